// File: rtl/col_east_drain.sv
`default_nettype none
// ============================================================================
//  Module      : col_east_drain
//  Description : East-edge reader for one PE column. Captures the column's
//                packed lane bus on a strobe and streams the enabled lanes
//                as single words over a valid/ready port. An active buffer
//                (ACT) drives the port while a shadow buffer (SHD) holds one
//                pending vector, so the column can issue back-to-back vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module col_east_drain #(
    parameter  int DATA_W = 25,
    parameter  int LANES  = 8,
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cap_en,
    input  logic [LANES*DATA_W-1:0] IN_VEC,
    input  logic [LANES-1:0]        LANE_MASK,
    output logic [DATA_W-1:0]       OUT_DATA,
    output logic [LW-1:0]           OUT_LANE,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    OUT_LAST,
    output logic                    BUSY,
    output logic                    OVERFLOW,
    input  logic                    CLR_OVF
);

    localparam logic [0:0]       c_idle = 1'b0;
    localparam logic [0:0]       c_send = 1'b1;
    localparam logic [LANES-1:0] c_one  = LANES'(1);

    // Registered state
    logic [0:0]              r_state;
    logic [LANES*DATA_W-1:0] r_act_vec;
    logic [LANES-1:0]        r_act_rem;   // lanes of ACT not yet emitted, current included
    logic [LANES*DATA_W-1:0] r_shd_vec;
    logic [LANES-1:0]        r_shd_mask;
    logic                    r_shd_full;
    logic [DATA_W-1:0]       r_out_data;
    logic [LW-1:0]           r_out_lane;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_ovf;

    // Next-state wires
    logic                    w_hs;
    logic                    w_finish;
    logic                    w_cap;
    logic                    w_drop;
    logic [LANES-1:0]        w_rem_after;
    logic [LANES*DATA_W-1:0] w_act_vec_nxt;
    logic [LANES-1:0]        w_act_rem_nxt;
    logic [LANES*DATA_W-1:0] w_shd_vec_nxt;
    logic [LANES-1:0]        w_shd_mask_nxt;
    logic                    w_shd_full_nxt;
    logic [0:0]              w_state_nxt;
    logic [LW-1:0]           w_lane_nxt;
    logic                    w_last_nxt;

    // Resolve handshake, finishing and capture into the next buffer contents
    always_comb begin
        w_hs           = r_out_valid & OUT_READY;
        w_finish       = w_hs & r_out_last;
        w_cap          = cap_en & (|LANE_MASK);
        w_rem_after    = r_act_rem & (r_act_rem - c_one);
        w_drop         = 1'b0;
        w_act_vec_nxt  = r_act_vec;
        w_act_rem_nxt  = w_hs ? w_rem_after : r_act_rem;
        w_shd_vec_nxt  = r_shd_vec;
        w_shd_mask_nxt = r_shd_mask;
        w_shd_full_nxt = r_shd_full;

        if (r_state == c_idle) begin
            // ACT is empty; SHD is always empty here because it promotes on finish
            if (w_cap) begin
                w_act_vec_nxt = IN_VEC;
                w_act_rem_nxt = LANE_MASK;
            end
        end else if (w_finish) begin
            if (r_shd_full) begin
                // Zero-bubble promotion; the capture (if any) refills SHD
                w_act_vec_nxt  = r_shd_vec;
                w_act_rem_nxt  = r_shd_mask;
                w_shd_full_nxt = w_cap;
                if (w_cap) begin
                    w_shd_vec_nxt  = IN_VEC;
                    w_shd_mask_nxt = LANE_MASK;
                end
            end else if (w_cap) begin
                w_act_vec_nxt = IN_VEC;
                w_act_rem_nxt = LANE_MASK;
            end
        end else if (w_cap) begin
            if (!r_shd_full) begin
                w_shd_vec_nxt  = IN_VEC;
                w_shd_mask_nxt = LANE_MASK;
                w_shd_full_nxt = 1'b1;
            end else begin
                w_drop = 1'b1;
            end
        end

        w_state_nxt = (|w_act_rem_nxt) ? c_send : c_idle;

        w_lane_nxt = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (w_act_rem_nxt[k]) begin
                w_lane_nxt = LW'(k);
            end
        end

        w_last_nxt = (|w_act_rem_nxt) &&
                     ((w_act_rem_nxt & (w_act_rem_nxt - c_one)) == '0);
    end

    // FSM, buffers and registered port outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_idle;
            r_act_vec   <= '0;
            r_act_rem   <= '0;
            r_shd_vec   <= '0;
            r_shd_mask  <= '0;
            r_shd_full  <= 1'b0;
            r_out_data  <= '0;
            r_out_lane  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_act_vec   <= w_act_vec_nxt;
            r_act_rem   <= w_act_rem_nxt;
            r_shd_vec   <= w_shd_vec_nxt;
            r_shd_mask  <= w_shd_mask_nxt;
            r_shd_full  <= w_shd_full_nxt;
            r_out_valid <= (w_state_nxt == c_send);
            r_out_last  <= w_last_nxt;
            r_out_lane  <= w_lane_nxt;
            r_out_data  <= w_act_vec_nxt[DATA_W*w_lane_nxt +: DATA_W];
            // A drop in the same cycle as a clear keeps the flag set
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (CLR_OVF) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign OUT_DATA  = r_out_data;
    assign OUT_LANE  = r_out_lane;
    assign OUT_VALID = r_out_valid;
    assign OUT_LAST  = r_out_last;
    assign BUSY      = (r_state == c_send);
    assign OVERFLOW  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_col_east_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_col_east_drain
//  Description : Self-checking bench for col_east_drain. A queue-of-beats
//                model predicts the port every cycle; directed scenarios add
//                hand-computed literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_col_east_drain;

    localparam int DW = 25;
    localparam int NL = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cap_en = 1'b0;
    logic [NL*DW-1:0] IN_VEC = '0;
    logic [NL-1:0]    LANE_MASK = '0;
    logic [DW-1:0]    OUT_DATA;
    logic [2:0]       OUT_LANE;
    logic             OUT_VALID;
    logic             OUT_READY = 1'b0;
    logic             OUT_LAST;
    logic             BUSY;
    logic             OVERFLOW;
    logic             CLR_OVF = 1'b0;

    int errors = 0;
    int checks = 0;
    bit model_on = 1'b0;

    col_east_drain #(.DATA_W(DW), .LANES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .IN_VEC(IN_VEC),
        .LANE_MASK(LANE_MASK), .OUT_DATA(OUT_DATA), .OUT_LANE(OUT_LANE),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST),
        .BUSY(BUSY), .OVERFLOW(OVERFLOW), .CLR_OVF(CLR_OVF)
    );

    always #5 clk = ~clk;

    // Model: every held vector is a run of beats; a vector ends at a last beat
    typedef struct {
        logic [2:0]    lane;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t q[$];
    bit    m_ovf = 1'b0;

    always @(posedge clk) begin
        int nvec;
        int fin;
        int hi;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            nvec = 0;
            foreach (q[i]) if (q[i].last) nvec++;
            fin = 0;
            if (q.size() > 0 && OUT_READY) begin
                fin = q[0].last ? 1 : 0;
                q.delete(0);
            end
            if (cap_en && LANE_MASK != 0) begin
                if (nvec - fin < 2) begin
                    hi = 0;
                    for (int k = 0; k < NL; k++) if (LANE_MASK[k]) hi = k;
                    for (int k = 0; k < NL; k++) begin
                        if (LANE_MASK[k]) begin
                            beat_t b;
                            b.lane = 3'(k);
                            b.data = IN_VEC[k*DW +: DW];
                            b.last = (k == hi);
                            q.push_back(b);
                        end
                    end
                    if (CLR_OVF) m_ovf = 1'b0;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (CLR_OVF) begin
                m_ovf = 1'b0;
            end
        end
    end

    // Compare the port against the model on every falling edge
    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if (OUT_VALID !== (q.size() > 0) || BUSY !== (q.size() > 0)) begin
                errors++;
                $display("FAIL model_valid: valid=%0b busy=%0b required=%0b",
                         OUT_VALID, BUSY, q.size() > 0);
            end
            checks++;
            if (OVERFLOW !== m_ovf) begin
                errors++;
                $display("FAIL model_ovf: got=%0b required=%0b", OVERFLOW, m_ovf);
            end
            if (q.size() > 0) begin
                checks++;
                if (OUT_DATA !== q[0].data || OUT_LANE !== q[0].lane || OUT_LAST !== q[0].last) begin
                    errors++;
                    $display("FAIL model_beat: got lane=%0d data=%h last=%0b required lane=%0d data=%h last=%0b",
                             OUT_LANE, OUT_DATA, OUT_LAST, q[0].lane, q[0].data, q[0].last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got=%h required=%h", name, got, req);
        end
    endtask

    // Advance one cycle; inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_vec(input logic [DW-1:0] base);
        for (int k = 0; k < NL; k++) IN_VEC[k*DW +: DW] = base + DW'(k);
    endtask

    task automatic capture(input logic [NL-1:0] m);
        cap_en = 1'b1;
        LANE_MASK = m;
        tick();
        cap_en = 1'b0;
        LANE_MASK = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (OUT_VALID && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'b0, OUT_VALID}, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {OUT_DATA, OUT_LANE, OUT_VALID, OUT_LAST, BUSY, OVERFLOW}, 32'd0);
    endtask

    initial begin
        logic [2:0] seen[$];

        // Watchdog so the run always ends
        fork
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // 1. Reset, full mask, READY=1
        tick(); tick();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        model_on = 1'b1;
        fill_vec(25'h100000);
        OUT_READY = 1'b1;
        capture(8'hFF);
        chk("t1_first_valid", {31'b0, OUT_VALID}, 32'd1);
        chk("t1_first_data", {7'b0, OUT_DATA}, 32'h0010_0000);
        for (int k = 0; k < NL; k++) begin
            chk("t1_lane", {29'b0, OUT_LANE}, k);
            chk("t1_last", {31'b0, OUT_LAST}, (k == 7) ? 32'd1 : 32'd0);
            tick();
        end
        chk("t1_done", {31'b0, OUT_VALID}, 32'd0);

        // 2. Sparse mask, READY toggling
        fill_vec(25'h0ABC00);
        OUT_READY = 1'b0;
        capture(8'b1010_0100);
        chk("t2_first_lane", {29'b0, OUT_LANE}, 32'd2);
        chk("t2_first_data", {7'b0, OUT_DATA}, 32'h000A_BC02);
        for (int i = 0; i < 20 && OUT_VALID; i++) begin
            OUT_READY = (i % 2 == 1);
            #1;
            if (OUT_VALID && OUT_READY) begin
                seen.push_back(OUT_LANE);
                if (OUT_LANE == 3'd7) chk("t2_last", {31'b0, OUT_LAST}, 32'd1);
            end
            tick();
        end
        chk("t2_count", seen.size(), 32'd3);
        if (seen.size() == 3) begin
            chk("t2_seq", {seen[0], seen[1], seen[2]}, {23'b0, 3'd2, 3'd5, 3'd7});
        end
        OUT_READY = 1'b0;

        // 3. Three back-to-back captures while stalled
        fill_vec(25'h011000);
        cap_en = 1'b1; LANE_MASK = 8'hFF; tick();
        fill_vec(25'h022000); tick();
        fill_vec(25'h033000); tick();
        cap_en = 1'b0; LANE_MASK = '0;
        chk("t3_ovf_set", {31'b0, OVERFLOW}, 32'd1);
        chk("t3_act_data", {7'b0, OUT_DATA}, 32'h0001_1000);
        OUT_READY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) chk("t3_second_vec", {7'b0, OUT_DATA}, 32'h0002_2000);
            chk("t3_no_gap", {31'b0, OUT_VALID}, 32'd1);
            tick();
        end
        chk("t3_done", {31'b0, OUT_VALID}, 32'd0);
        CLR_OVF = 1'b1; tick(); CLR_OVF = 1'b0;
        chk("t3_ovf_clr", {31'b0, OVERFLOW}, 32'd0);

        // 4. Capture coincident with the final handshake, SHD empty
        fill_vec(25'h044000);
        capture(8'h01);
        chk("t4_first_last", {31'b0, OUT_LAST}, 32'd1);
        fill_vec(25'h055000);
        capture(8'h01);
        chk("t4_next_valid", {31'b0, OUT_VALID}, 32'd1);
        chk("t4_next_data", {7'b0, OUT_DATA}, 32'h0005_5000);
        chk("t4_no_ovf", {31'b0, OVERFLOW}, 32'd0);
        wait_idle(4);

        // 5. Empty mask is ignored
        capture(8'h00);
        capture(8'h00);
        chk("t5_quiet", {29'b0, OUT_VALID, BUSY, OVERFLOW}, 32'd0);

        // 6. Reset during beat 3 of 8
        fill_vec(25'h066000);
        capture(8'hFF);
        tick(); tick(); tick();
        chk("t6_beat3_lane", {29'b0, OUT_LANE}, 32'd3);
        rst_n = 1'b0;
        tick();
        chk_all_zero("t6_reset_zero");
        rst_n = 1'b1;
        fill_vec(25'h077000);
        capture(8'b0011_0000);
        chk("t6_restart_lane", {29'b0, OUT_LANE}, 32'd4);
        chk("t6_restart_data", {7'b0, OUT_DATA}, 32'h0007_7004);
        wait_idle(6);

        tick();
        model_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
